// File: rtl/mem_access_seq.sv
// Memory access sequencer for the multicycle CPU: arbitrates fetch/data/exception
// requests, drives the address-mux select and MemWR, and times the memory latency.
module mem_access_seq #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       data_we,
  input  logic [1:0] data_addr_sel,
  input  logic       exc_req,
  input  logic [1:0] exc_code,
  output logic [2:0] IorDControl,
  output logic       MemWR,
  output logic       busy,
  output logic       done,
  output logic [1:0] done_src,
  output logic       ld_ir,
  output logic       ld_mdr,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACCESS   = 2'b01,
    ST_COMPLETE = 2'b10
  } state_e;

  localparam logic [1:0] SRC_FETCH = 2'b00;
  localparam logic [1:0] SRC_DATA  = 2'b01;
  localparam logic [1:0] SRC_EXC   = 2'b10;
  localparam logic [3:0] CNT_LAST  = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic       we_q, we_d;
  logic [1:0] src_q, src_d;
  logic       illegal_s;

  logic [2:0] iord_q, iord_d;
  logic       memwr_q, memwr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] done_src_q, done_src_d;
  logic       ld_ir_q, ld_ir_d;
  logic       ld_mdr_q, ld_mdr_d;
  logic       err_q, err_d;

  // State, latched request attributes and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      sel_q      <= 3'b000;
      we_q       <= 1'b0;
      src_q      <= SRC_FETCH;
      iord_q     <= 3'b000;
      memwr_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_src_q <= 2'b00;
      ld_ir_q    <= 1'b0;
      ld_mdr_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      src_q      <= src_d;
      iord_q     <= iord_d;
      memwr_q    <= memwr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_src_q <= done_src_d;
      ld_ir_q    <= ld_ir_d;
      ld_mdr_q   <= ld_mdr_d;
      err_q      <= err_d;
    end
  end

  // Arbitration (exc > data > fetch) in IDLE and latency counting in ACCESS.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    we_d      = we_q;
    src_d     = src_q;
    illegal_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exc_req) begin
          if (exc_code == 2'b00) begin
            illegal_s = 1'b1;
          end else begin
            sel_d   = {1'b0, exc_code};
            we_d    = 1'b0;
            src_d   = SRC_EXC;
            cnt_d   = 4'd0;
            state_d = ST_ACCESS;
          end
        end else if (data_req) begin
          if (data_addr_sel == 2'b11) begin
            illegal_s = 1'b1;
          end else begin
            sel_d   = {1'b1, data_addr_sel};
            we_d    = data_we;
            src_d   = SRC_DATA;
            cnt_d   = 4'd0;
            state_d = ST_ACCESS;
          end
        end else if (fetch_req) begin
          sel_d   = 3'b000;
          we_d    = 1'b0;
          src_d   = SRC_FETCH;
          cnt_d   = 4'd0;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_COMPLETE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs derived from the next state so they line up with the state they describe.
  always_comb begin
    iord_d     = 3'b000;
    memwr_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    done_src_d = 2'b00;
    ld_ir_d    = 1'b0;
    ld_mdr_d   = 1'b0;
    err_d      = illegal_s;
    case (state_d)
      ST_IDLE: begin
        iord_d = 3'b000;
      end
      ST_ACCESS: begin
        iord_d  = sel_d;
        busy_d  = 1'b1;
        memwr_d = we_d;
      end
      ST_COMPLETE: begin
        iord_d     = sel_d;
        busy_d     = 1'b1;
        done_d     = 1'b1;
        done_src_d = src_d;
        if (src_d == SRC_FETCH) begin
          ld_ir_d = 1'b1;
        end else if (src_d == SRC_EXC) begin
          ld_mdr_d = 1'b1;
        end else begin
          ld_mdr_d = ~we_d;
        end
      end
      default: begin
        iord_d = 3'b000;
      end
    endcase
  end

  assign IorDControl = iord_q;
  assign MemWR       = memwr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_src    = done_src_q;
  assign ld_ir       = ld_ir_q;
  assign ld_mdr      = ld_mdr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: per-cycle vector table on a MEM_LAT=2 instance,
// plus hand sequences for latency and a MEM_LAT=1 instance.
module tb_mem_access_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MEM_LAT=2 instance signals
  logic       rst2 = 1'b0, f2 = 1'b0, d2 = 1'b0, we2 = 1'b0, e2 = 1'b0;
  logic [1:0] ds2 = 2'b00, ec2 = 2'b00;
  logic [2:0] iord2;
  logic       mw2, busy2, done2, ir2, mdr2, err2;
  logic [1:0] src2;

  // MEM_LAT=1 instance signals
  logic       rst1 = 1'b0, f1 = 1'b0, d1 = 1'b0, we1 = 1'b0, e1 = 1'b0;
  logic [1:0] ds1 = 2'b00, ec1 = 2'b00;
  logic [2:0] iord1;
  logic       mw1, busy1, done1, ir1, mdr1, err1;
  logic [1:0] src1;

  mem_access_seq #(.MEM_LAT(2)) dut2 (
    .clk(clk), .reset(rst2), .fetch_req(f2), .data_req(d2), .data_we(we2),
    .data_addr_sel(ds2), .exc_req(e2), .exc_code(ec2),
    .IorDControl(iord2), .MemWR(mw2), .busy(busy2), .done(done2),
    .done_src(src2), .ld_ir(ir2), .ld_mdr(mdr2), .err(err2)
  );

  mem_access_seq #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(rst1), .fetch_req(f1), .data_req(d1), .data_we(we1),
    .data_addr_sel(ds1), .exc_req(e1), .exc_code(ec1),
    .IorDControl(iord1), .MemWR(mw1), .busy(busy1), .done(done1),
    .done_src(src1), .ld_ir(ir1), .ld_mdr(mdr1), .err(err1)
  );

  // Observed outputs packed as {iord, memwr, busy, done, src, ld_ir, ld_mdr, err}
  logic [10:0] obs2, obs1;
  assign obs2 = {iord2, mw2, busy2, done2, src2, ir2, mdr2, err2};
  assign obs1 = {iord1, mw1, busy1, done1, src1, ir1, mdr1, err1};

  typedef struct {
    logic        rst, f, d, we, e;
    logic [1:0]  ds, ec;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(input string name, input logic rst, input logic f,
                             input logic d, input logic we, input logic [1:0] ds,
                             input logic e, input logic [1:0] ec,
                             input logic [2:0] iord, input logic mw, input logic bsy,
                             input logic dn, input logic [1:0] src, input logic ir,
                             input logic mdr, input logic er);
    vec_t r;
    r.name = name; r.rst = rst; r.f = f; r.d = d; r.we = we; r.ds = ds;
    r.e = e; r.ec = ec;
    r.exp = {iord, mw, bsy, dn, src, ir, mdr, er};
    return r;
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {iord,mw,busy,done,src,ir,mdr,err}=%b required %b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  initial begin
    int lat;
    bit seen;
    //               name       rst f  d  we ds     e  ec     iord    mw bsy dn src    ir mdr er
    vecs.push_back(v("rst0",    0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("rst1",    0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("idle",    1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("fe_a0",   1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("fe_a1",   1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("fe_done", 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1, 2'b00, 1, 0, 0));
    vecs.push_back(v("fe_idle", 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("st_a0",   1, 0, 1, 1, 2'b10, 0, 2'b00, 3'b110, 1, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("st_a1",   1, 0, 1, 1, 2'b10, 0, 2'b00, 3'b110, 1, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("st_done", 1, 0, 1, 1, 2'b10, 0, 2'b00, 3'b110, 0, 1, 1, 2'b01, 0, 0, 0));
    vecs.push_back(v("st_idle", 1, 0, 0, 0, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("pr_ex0",  1, 1, 1, 0, 2'b00, 1, 2'b10, 3'b010, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("pr_ex1",  1, 1, 1, 0, 2'b00, 1, 2'b10, 3'b010, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("pr_exd",  1, 1, 1, 0, 2'b00, 1, 2'b10, 3'b010, 0, 1, 1, 2'b10, 0, 1, 0));
    vecs.push_back(v("pr_idl1", 1, 1, 1, 0, 2'b00, 0, 2'b10, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("pr_ld0",  1, 1, 1, 0, 2'b00, 0, 2'b10, 3'b100, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("pr_ld1",  1, 1, 1, 0, 2'b00, 0, 2'b10, 3'b100, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("pr_ldd",  1, 1, 1, 0, 2'b00, 0, 2'b10, 3'b100, 0, 1, 1, 2'b01, 0, 1, 0));
    vecs.push_back(v("pr_idl2", 1, 1, 0, 0, 2'b00, 0, 2'b10, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("pr_fe0",  1, 1, 0, 0, 2'b00, 0, 2'b10, 3'b000, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("pr_fe1",  1, 1, 0, 0, 2'b00, 0, 2'b10, 3'b000, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("pr_fed",  1, 1, 0, 0, 2'b00, 0, 2'b10, 3'b000, 0, 1, 1, 2'b00, 1, 0, 0));
    vecs.push_back(v("pr_idl3", 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("ill_ex0", 1, 0, 0, 0, 2'b00, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1));
    vecs.push_back(v("ill_ex1", 1, 1, 0, 0, 2'b00, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1));
    vecs.push_back(v("ill_d0",  1, 0, 1, 0, 2'b11, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1));
    vecs.push_back(v("ill_d1",  1, 0, 1, 1, 2'b11, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1));
    vecs.push_back(v("ill_end", 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("ab_a0",   1, 0, 1, 1, 2'b01, 0, 2'b00, 3'b101, 1, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("ab_rst",  0, 0, 1, 1, 2'b01, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("ab_idle", 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("np_ld0",  1, 0, 1, 0, 2'b00, 0, 2'b00, 3'b100, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("np_ld1",  1, 0, 1, 0, 2'b00, 1, 2'b01, 3'b100, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("np_ldd",  1, 0, 1, 0, 2'b00, 1, 2'b01, 3'b100, 0, 1, 1, 2'b01, 0, 1, 0));
    vecs.push_back(v("np_idle", 1, 0, 0, 0, 2'b00, 1, 2'b01, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("np_ex0",  1, 0, 0, 0, 2'b00, 1, 2'b01, 3'b001, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("np_ex1",  1, 0, 0, 0, 2'b00, 1, 2'b01, 3'b001, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("np_exd",  1, 0, 0, 0, 2'b00, 1, 2'b01, 3'b001, 0, 1, 1, 2'b10, 0, 1, 0));
    vecs.push_back(v("no_idle", 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("no_a0",   1, 0, 0, 0, 2'b00, 1, 2'b11, 3'b011, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("no_a1",   1, 0, 0, 0, 2'b00, 1, 2'b11, 3'b011, 0, 1, 0, 2'b00, 0, 0, 0));
    vecs.push_back(v("no_done", 1, 0, 0, 0, 2'b00, 1, 2'b11, 3'b011, 0, 1, 1, 2'b10, 0, 1, 0));
    vecs.push_back(v("end_idl", 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst2 = vecs[i].rst; f2 = vecs[i].f; d2 = vecs[i].d; we2 = vecs[i].we;
      ds2 = vecs[i].ds; e2 = vecs[i].e; ec2 = vecs[i].ec;
      @(posedge clk); #1;
      chk(vecs[i].name, obs2, vecs[i].exp);
    end

    // Bounded latency measurement: done must appear MEM_LAT+1 edges after sampling.
    f2 = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (done2) begin
        seen = 1'b1;
        lat = c;
      end
    end
    f2 = 1'b0;
    chk1("lat2_seen", seen, 1'b1);
    chk1("lat2_edges", (lat == 3), 1'b1);
    @(posedge clk); #1;

    // MEM_LAT=1 instance: load from RegA.
    rst1 = 1'b1;
    @(posedge clk); #1;
    chk("m1_idle", obs1, 11'b000_0_0_0_00_0_0_0);
    d1 = 1'b1; we1 = 1'b0; ds1 = 2'b01;
    @(posedge clk); #1;
    chk("m1_acc", obs1, 11'b101_0_1_0_00_0_0_0);
    @(posedge clk); #1;
    chk("m1_done", obs1, 11'b101_0_1_1_01_0_1_0);
    d1 = 1'b0;
    @(posedge clk); #1;
    chk("m1_idle2", obs1, 11'b000_0_0_0_00_0_0_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
